// File: rtl/player_move_ctrl.sv
// -----------------------------------------------------------------------------
// player_move_ctrl
//
// Purpose:
//   Moves a single box through a maze. One direction request is accepted at a
//   time, and the target cell is looked up in an external wall memory. If the
//   cell is open, the box is erased at the old cell, the new position is
//   committed, and the box is drawn at the new cell. Blocked moves produce a
//   one-cycle bump pulse. Reaching the exit cell latches at_exit and parks the
//   controller in WIN.
//   This block is the only source of cell coordinates and erase/draw strobes
//   for the downstream pixel stages.
//
// Optional feature (macro PLAYER_MOVE_CNT_EN):
//   Adds output move_cnt[15:0], which counts completed moves and saturates at
//   16'hFFFF. When the macro is undefined, the port and counter do not exist.
//
// Ports:
//   clk         in   1   system clock
//   resetn      in   1   synchronous active-low reset
//   move_req    in   1   move request, sampled only in IDLE
//   move_dir    in   2   00 up, 01 down, 10 left, 11 right
//   mem_addr    out  10  wall memory address = y*GRID_W + x
//   mem_rdata   in   1   1 = wall, valid one cycle after mem_addr changes
//   box_x       out  5   cell x for the erase/draw stages
//   box_y       out  5   cell y for the erase/draw stages
//   erase_box   out  1   erase strobe (level)
//   erase_done  in   1   erase stage finished
//   draw_box    out  1   draw strobe (level)
//   draw_done   in   1   draw stage finished
//   busy        out  1   high in every state except IDLE and WIN
//   bump        out  1   one-cycle pulse on a blocked move
//   at_exit     out  1   sticky exit flag
//   move_cnt    out  16  completed-move count (PLAYER_MOVE_CNT_EN only)
//   dbg_state   out  4   current FSM state encoding
//
// Strobe handshake: erase_box/draw_box rise on entry to the owning state. They
// stay high, with box_x/box_y frozen, until the matching done input is seen
// while the strobe is high. They then drop for at least one gap cycle, so the
// stage can clear its done flag before the next strobe.
// -----------------------------------------------------------------------------
module player_move_ctrl #(
    parameter int GRID_W  = 24,
    parameter int GRID_H  = 24,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int EXIT_X  = 23,
    parameter int EXIT_Y  = 23
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        move_req,
    input  logic [1:0]  move_dir,
    output logic [9:0]  mem_addr,
    input  logic        mem_rdata,
    output logic [4:0]  box_x,
    output logic [4:0]  box_y,
    output logic        erase_box,
    input  logic        erase_done,
    output logic        draw_box,
    input  logic        draw_done,
    output logic        busy,
    output logic        bump,
    output logic        at_exit,
`ifdef PLAYER_MOVE_CNT_EN
    output logic [15:0] move_cnt,
`endif
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_INIT_DRAW = 4'd0,
        S_IDLE      = 4'd1,
        S_RD        = 4'd2,
        S_CHK       = 4'd3,
        S_ERASE     = 4'd4,
        S_ERASE_GAP = 4'd5,
        S_DRAW      = 4'd6,
        S_DRAW_GAP  = 4'd7,
        S_WIN       = 4'd8
    } state_e;

    localparam logic [4:0] X_MAX    = 5'(GRID_W - 1);
    localparam logic [4:0] Y_MAX    = 5'(GRID_H - 1);
    localparam logic [4:0] X_START  = 5'(START_X);
    localparam logic [4:0] Y_START  = 5'(START_Y);
    localparam logic [4:0] X_EXIT   = 5'(EXIT_X);
    localparam logic [4:0] Y_EXIT   = 5'(EXIT_Y);
    localparam logic [9:0] GRID_W10 = 10'(GRID_W);

    state_e     state_q, state_d;
    logic [4:0] box_x_q, box_x_d;
    logic [4:0] box_y_q, box_y_d;
    logic [4:0] tgt_x_q, tgt_x_d;
    logic [4:0] tgt_y_q, tgt_y_d;
    logic [9:0] mem_addr_q, mem_addr_d;
    logic       erase_q, erase_d;
    logic       draw_q, draw_d;
    logic       bump_q, bump_d;
    logic       at_exit_q, at_exit_d;

    // Candidate target cell for the current request. Bounds are tested on the
    // unmodified coordinate, so a decrement at 0 never wraps.
    logic [4:0] nxt_x, nxt_y;
    logic       oob;
    logic [9:0] nxt_addr;

    always_comb begin
        nxt_x = box_x_q;
        nxt_y = box_y_q;
        oob   = 1'b0;
        case (move_dir)
            2'b00: begin
                if (box_y_q == 5'd0) oob = 1'b1;
                else                 nxt_y = box_y_q - 5'd1;
            end
            2'b01: begin
                if (box_y_q >= Y_MAX) oob = 1'b1;
                else                  nxt_y = box_y_q + 5'd1;
            end
            2'b10: begin
                if (box_x_q == 5'd0) oob = 1'b1;
                else                 nxt_x = box_x_q - 5'd1;
            end
            default: begin
                if (box_x_q >= X_MAX) oob = 1'b1;
                else                  nxt_x = box_x_q + 5'd1;
            end
        endcase
    end

    assign nxt_addr = ({5'd0, nxt_y} * GRID_W10) + {5'd0, nxt_x};

    // Next-state and register updates
    always_comb begin
        state_d    = state_q;
        box_x_d    = box_x_q;
        box_y_d    = box_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        mem_addr_d = mem_addr_q;
        bump_d     = 1'b0;
        at_exit_d  = at_exit_q;

        case (state_q)
            S_INIT_DRAW: begin
                if (draw_q && draw_done) state_d = S_DRAW_GAP;
            end
            S_IDLE: begin
                if (move_req) begin
                    if (oob) begin
                        bump_d = 1'b1;
                    end else begin
                        tgt_x_d    = nxt_x;
                        tgt_y_d    = nxt_y;
                        mem_addr_d = nxt_addr;
                        state_d    = S_RD;
                    end
                end
            end
            // The memory answers one cycle after the address changes.
            S_RD: state_d = S_CHK;
            S_CHK: begin
                if (mem_rdata) begin
                    bump_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                if (erase_q && erase_done) state_d = S_ERASE_GAP;
            end
            S_ERASE_GAP: begin
                box_x_d = tgt_x_q;
                box_y_d = tgt_y_q;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (draw_q && draw_done) state_d = S_DRAW_GAP;
            end
            S_DRAW_GAP: begin
                if (box_x_q == X_EXIT && box_y_q == Y_EXIT) begin
                    at_exit_d = 1'b1;
                    state_d   = S_WIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WIN: state_d = S_WIN;
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state. They rise with the state
        // entry and are forced low in the reset cycle.
        erase_d = (state_d == S_ERASE);
        draw_d  = (state_d == S_DRAW) || (state_d == S_INIT_DRAW);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_INIT_DRAW;
            box_x_q    <= X_START;
            box_y_q    <= Y_START;
            tgt_x_q    <= X_START;
            tgt_y_q    <= Y_START;
            mem_addr_q <= 10'd0;
            erase_q    <= 1'b0;
            draw_q     <= 1'b0;
            bump_q     <= 1'b0;
            at_exit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            box_x_q    <= box_x_d;
            box_y_q    <= box_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            mem_addr_q <= mem_addr_d;
            erase_q    <= erase_d;
            draw_q     <= draw_d;
            bump_q     <= bump_d;
            at_exit_q  <= at_exit_d;
        end
    end

`ifdef PLAYER_MOVE_CNT_EN
    logic [15:0] move_cnt_q, move_cnt_d;

    // Counts entries into ERASE_GAP, which happen only for moves that completed
    // their erase.
    always_comb begin
        move_cnt_d = move_cnt_q;
        if (state_q == S_ERASE && state_d == S_ERASE_GAP && move_cnt_q != 16'hFFFF)
            move_cnt_d = move_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) move_cnt_q <= 16'd0;
        else         move_cnt_q <= move_cnt_d;
    end

    assign move_cnt = move_cnt_q;
`endif

    assign mem_addr  = mem_addr_q;
    assign box_x     = box_x_q;
    assign box_y     = box_y_q;
    assign erase_box = erase_q;
    assign draw_box  = draw_q;
    assign bump      = bump_q;
    assign at_exit   = at_exit_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_WIN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_move_ctrl
//
// Bench for player_move_ctrl. A reference model tracks the box position, the
// wall map, the exit flag and the completed-move count. Each request pushes
// the visible events it should cause into exp_q. A monitor pops and compares
// those events as the DUT produces them. Events are erase rise, draw rise,
// each bump cycle, and the at_exit rise.
// -----------------------------------------------------------------------------
module tb_player_move_ctrl;
    localparam int GW = 24;
    localparam int GH = 24;
    localparam int SX = 0;
    localparam int SY = 0;
    localparam int EX = 23;
    localparam int EY = 23;

    localparam logic [1:0] EV_ERASE = 2'd0;
    localparam logic [1:0] EV_DRAW  = 2'd1;
    localparam logic [1:0] EV_BUMP  = 2'd2;
    localparam logic [1:0] EV_EXIT  = 2'd3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        move_req = 1'b0;
    logic [1:0]  move_dir = 2'd0;
    logic [9:0]  mem_addr;
    logic        mem_rdata = 1'b0;
    logic [4:0]  box_x, box_y;
    logic        erase_box, draw_box;
    logic        erase_done = 1'b0;
    logic        draw_done = 1'b0;
    logic        busy, bump, at_exit;
    logic [3:0]  dbg_state;
`ifdef PLAYER_MOVE_CNT_EN
    logic [15:0] move_cnt;
`endif

    player_move_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .START_X(SX), .START_Y(SY), .EXIT_X(EX), .EXIT_Y(EY)
    ) dut (
        .clk(clk), .resetn(resetn), .move_req(move_req), .move_dir(move_dir),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .box_x(box_x), .box_y(box_y),
        .erase_box(erase_box), .erase_done(erase_done), .draw_box(draw_box),
        .draw_done(draw_done), .busy(busy), .bump(bump), .at_exit(at_exit),
`ifdef PLAYER_MOVE_CNT_EN
        .move_cnt(move_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    logic [11:0] exp_q[$];

    // ---------------- reference model ----------------
    int px, py, cnt_model;
    bit won;
    bit wall [0:1023];
    bit hold_erase = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [11:0] ev(input logic [1:0] kind, input int x, input int y);
        return {kind, 5'(x), 5'(y)};
    endfunction

    // ---------------- wall memory: data valid one cycle after address ----------------
    logic [9:0] addr_d1 = 10'd0;
    always @(negedge clk) begin
        mem_rdata = wall[addr_d1];
        addr_d1 = (^mem_addr === 1'bx) ? 10'd0 : mem_addr;
    end

    // ---------------- erase/draw stage responders ----------------
    int e_wait = 0;
    int d_wait = 0;
    always @(negedge clk) begin
        if (erase_done) erase_done = 1'b0;
        else if (resetn && erase_box === 1'b1 && !hold_erase) begin
            if (e_wait == 0) begin
                erase_done = 1'b1;
                e_wait = $urandom_range(0, 3);
            end else e_wait--;
        end else if (resetn && busy === 1'b0 && $urandom_range(0, 7) == 0)
            erase_done = 1'b1;  // stray pulse, must be ignored
    end

    always @(negedge clk) begin
        if (draw_done) draw_done = 1'b0;
        else if (resetn && draw_box === 1'b1) begin
            if (d_wait == 0) begin
                draw_done = 1'b1;
                d_wait = $urandom_range(0, 3);
            end else d_wait--;
        end else if (resetn && busy === 1'b0 && $urandom_range(0, 7) == 0)
            draw_done = 1'b1;  // stray pulse, must be ignored
    end

    // ---------------- monitor ----------------
    bit prev_e = 1'b0, prev_d = 1'b0, prev_exit = 1'b0;
    logic [4:0] prev_x = 5'd0, prev_y = 5'd0;

    task automatic got(input logic [11:0] e);
        logic [11:0] want;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event act=%0h req=none t=%0t", e, $time);
        end else begin
            want = exp_q.pop_front();
            check("event", e, want);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (erase_box === 1'b1 || draw_box === 1'b1)
                check("strobe_exclusive", {31'd0, erase_box & draw_box}, 0);
            if ((erase_box === 1'b1 && prev_e) || (draw_box === 1'b1 && prev_d)) begin
                check("box_hold_x", box_x, prev_x);
                check("box_hold_y", box_y, prev_y);
            end
            if (erase_box === 1'b1 && !prev_e) begin
                check("gap_before_erase", prev_d, 0);
                got(ev(EV_ERASE, box_x, box_y));
            end
            if (draw_box === 1'b1 && !prev_d) begin
                check("gap_before_draw", prev_e, 0);
                got(ev(EV_DRAW, box_x, box_y));
            end
            if (bump === 1'b1) got(ev(EV_BUMP, box_x, box_y));
            if (at_exit === 1'b1 && !prev_exit) got(ev(EV_EXIT, box_x, box_y));
        end
        prev_e = (erase_box === 1'b1);
        prev_d = (draw_box === 1'b1);
        prev_exit = (at_exit === 1'b1);
        prev_x = box_x;
        prev_y = box_y;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(busy === 1'b0 && exp_q.size() == 0) && n < 300) begin
            step();
            n++;
        end
        check("idle_timeout", {31'd0, n < 300}, 1);
    endtask

    task automatic check_cnt();
`ifdef PLAYER_MOVE_CNT_EN
        check("move_cnt", move_cnt, cnt_model);
`endif
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        move_req = 1'b0;
        step();
        check("rst_box_x", box_x, SX);
        check("rst_box_y", box_y, SY);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_erase", erase_box, 0);
        check("rst_draw", draw_box, 0);
        check("rst_bump", bump, 0);
        check("rst_at_exit", at_exit, 0);
        check("rst_busy", busy, 1);
`ifdef PLAYER_MOVE_CNT_EN
        check("rst_move_cnt", move_cnt, 0);
`endif
        hold_erase = 1'b0;
        step();
        exp_q.delete();
        px = SX;
        py = SY;
        won = 1'b0;
        cnt_model = 0;
        exp_q.push_back(ev(EV_DRAW, SX, SY));
        resetn = 1'b1;
        wait_idle();
    endtask

    task automatic do_move(input logic [1:0] dir, input bit settle);
        int tx, ty;
        bit oob, blk;
        logic [9:0] addr0;
        tx = px;
        ty = py;
        case (dir)
            2'd0: ty = py - 1;
            2'd1: ty = py + 1;
            2'd2: tx = px - 1;
            default: tx = px + 1;
        endcase
        oob = (tx < 0) || (tx >= GW) || (ty < 0) || (ty >= GH);
        blk = !oob && wall[ty * GW + tx];
        addr0 = mem_addr;
        move_dir = dir;
        move_req = 1'b1;
        if (!won) begin
            if (oob || blk) exp_q.push_back(ev(EV_BUMP, px, py));
            else begin
                exp_q.push_back(ev(EV_ERASE, px, py));
                exp_q.push_back(ev(EV_DRAW, tx, ty));
                if (tx == EX && ty == EY) exp_q.push_back(ev(EV_EXIT, tx, ty));
            end
        end
        step();  // T1
        move_req = 1'b0;
        if (won) begin
            check("win_no_bump_t1", bump, 0);
        end else if (oob) begin
            check("oob_bump_t1", bump, 1);
            check("oob_no_read", mem_addr, addr0);
        end else begin
            check("addr_t1", mem_addr, ty * GW + tx);
        end
        step();
        step();  // T3
        if (won || oob) check("no_erase_t3", erase_box, 0);
        else if (blk) check("wall_bump_t3", bump, 1);
        else check("erase_t3", erase_box, 1);
        if (!won && !oob && !blk) begin
            px = tx;
            py = ty;
            cnt_model++;
            if (tx == EX && ty == EY) won = 1'b1;
        end
        if (settle) wait_idle();
    endtask

    task automatic clear_walls();
        for (int i = 0; i < 1024; i++) wall[i] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_walls();
        do_reset();
        check("idle_busy", busy, 0);

        // directed moves from the start cell
        do_move(2'd0, 1'b1);          // up at y=0: out of bounds
        do_move(2'd3, 1'b1);          // right, open: addr 1
        check("pos_x", box_x, 1);
        do_move(2'd3, 1'b1);
        do_move(2'd1, 1'b1);
        do_move(2'd1, 1'b1);
        do_move(2'd1, 1'b1);          // now (2,3)
        wall[4 * GW + 2] = 1'b1;
        do_move(2'd1, 1'b1);          // wall at (2,4): addr 98
        check("wall_stay_x", box_x, 2);
        check("wall_stay_y", box_y, 3);
        check_cnt();

        // randomized walk over a random wall map
        for (int i = 0; i < GW * GH; i++) wall[i] = ($urandom_range(0, 3) == 0);
        wall[py * GW + px] = 1'b0;
        for (int i = 0; i < 150; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            do_move(2'($urandom_range(0, 3)), 1'b1);
        end
        check("rand_x", box_x, px);
        check("rand_y", box_y, py);
        check_cnt();

        // walk to the exit on an open map
        clear_walls();
        do_reset();
        do_move(2'd2, 1'b1);          // left at x=0: out of bounds
        for (int i = 0; i < 22; i++) do_move(2'd3, 1'b1);
        for (int i = 0; i < 23; i++) do_move(2'd1, 1'b1);
        do_move(2'd1, 1'b1);          // down at y=23: out of bounds
        do_move(2'd3, 1'b1);          // into the exit
        check("exit_flag", at_exit, 1);
        check("exit_busy", busy, 0);
        check_cnt();
        for (int i = 0; i < 3; i++) do_move(2'($urandom_range(0, 3)), 1'b1);
        check("win_hold_x", box_x, EX);
        check("win_hold_y", box_y, EY);
        check("win_flag", at_exit, 1);
        check_cnt();

        // reset while an erase is outstanding at (5,5)
        do_reset();
        for (int i = 0; i < 5; i++) do_move(2'd3, 1'b1);
        for (int i = 0; i < 5; i++) do_move(2'd1, 1'b1);
        hold_erase = 1'b1;
        do_move(2'd3, 1'b0);
        step();
        check("erase_held", erase_box, 1);
        check("erase_held_x", box_x, 5);
        do_reset();
        check("post_reset_x", box_x, SX);
        check("post_reset_y", box_y, SY);
        check_cnt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
